// File: rtl/rv_fpu_csr_responder_pkg.sv
// Shared types and constants for the FPU<->CSR responder.
// Optional feature macro: FPU_FFLAGS_CNT_EN (see rv_fpu_csr_responder.sv).
package rv_fpu_csr_responder_pkg;

  localparam int unsigned NUM_WARPS     = 4;
  localparam int unsigned NW_BITS       = $clog2(NUM_WARPS);
  localparam int unsigned UUID_BITS     = 8;
  localparam int unsigned INST_FRM_BITS = 3;
  localparam int unsigned FFLAGS_BITS   = 5;

  localparam logic [11:0] CSR_FFLAGS = 12'h001;
  localparam logic [11:0] CSR_FRM    = 12'h002;
  localparam logic [11:0] CSR_FCSR   = 12'h003;

  typedef logic [NW_BITS-1:0] wid_t;

  typedef enum logic [1:0] {
    CsrOpRead = 2'b00,
    CsrOpRw   = 2'b01,
    CsrOpRs   = 2'b10,
    CsrOpRc   = 2'b11
  } csr_op_e;

  typedef enum logic {
    StIdle,
    StResp
  } state_e;

  // Only the low 8 bits matter: no fcsr field lives above bit 7.
  function automatic logic [7:0] csr_alu(csr_op_e op, logic [7:0] old_val, logic [7:0] wdata);
    unique case (op)
      CsrOpRw: csr_alu = wdata;
      CsrOpRs: csr_alu = old_val | wdata;
      CsrOpRc: csr_alu = old_val & ~wdata;
      default: csr_alu = old_val;
    endcase
  endfunction

endpackage

// File: rtl/rv_fpu_csr_responder_fcsr_bank.sv
// Per-warp fcsr storage: FPU frm read port, CSR read-modify-write port, sticky flag OR port.
module rv_fcsr_bank
  import rv_fpu_csr_responder_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  wid_t                     rd_wid,
  output logic [INST_FRM_BITS-1:0] rd_frm,
  input  wid_t                     csr_wid,
  input  logic [11:0]              csr_addr,
  output logic [7:0]               csr_old,
  input  logic                     csr_we,
  input  logic [7:0]               csr_new,
  input  logic                     flag_we,
  input  wid_t                     flag_wid,
  input  logic [FFLAGS_BITS-1:0]   flag_fflags
);

  logic [FFLAGS_BITS-1:0]   fflags_q [NUM_WARPS];
  logic [FFLAGS_BITS-1:0]   fflags_d [NUM_WARPS];
  logic [INST_FRM_BITS-1:0] frm_q    [NUM_WARPS];
  logic [INST_FRM_BITS-1:0] frm_d    [NUM_WARPS];

  assign rd_frm = frm_q[rd_wid];

  // CSR view of the addressed register; unknown addresses read as zero.
  always_comb begin
    csr_old = '0;
    case (csr_addr)
      CSR_FFLAGS: csr_old = {3'b0, fflags_q[csr_wid]};
      CSR_FRM:    csr_old = {5'b0, frm_q[csr_wid]};
      CSR_FCSR:   csr_old = {frm_q[csr_wid], fflags_q[csr_wid]};
      default:    csr_old = '0;
    endcase
  end

  // CSR write lands first, then FPU flags are ORed on top so no flag is ever lost.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      fflags_d[w] = fflags_q[w];
      frm_d[w]    = frm_q[w];
      if (csr_we && (csr_wid == wid_t'(w))) begin
        case (csr_addr)
          CSR_FFLAGS: fflags_d[w] = csr_new[4:0];
          CSR_FRM:    frm_d[w]    = csr_new[2:0];
          CSR_FCSR: begin
            fflags_d[w] = csr_new[4:0];
            frm_d[w]    = csr_new[7:5];
          end
          default: ;
        endcase
      end
      if (flag_we && (flag_wid == wid_t'(w))) begin
        fflags_d[w] = fflags_d[w] | flag_fflags;
      end
    end
  end

  // Storage registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        fflags_q[w] <= '0;
        frm_q[w]    <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        fflags_q[w] <= fflags_d[w];
        frm_q[w]    <= frm_d[w];
      end
    end
  end

endmodule

// File: rtl/rv_fpu_csr_responder.sv
// CSR-side end of the FPU<->CSR interface: request/response FSM, pending vector, flag counter.
// Define FPU_FFLAGS_CNT_EN to enable the saturating count of nonzero FPU flag writes.
module rv_fpu_csr_responder
  import rv_fpu_csr_responder_pkg::*;
#(
  parameter int unsigned CORE_ID = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NW_BITS-1:0]       fpu_read_wid,
  output logic [INST_FRM_BITS-1:0] fpu_read_frm,
  input  logic                     fpu_write_enable,
  input  logic [NW_BITS-1:0]       fpu_write_wid,
  input  logic [FFLAGS_BITS-1:0]   fpu_write_fflags,
  input  logic [NUM_WARPS-1:0]     fpu_pending,
  input  logic                     csr_req_valid,
  output logic                     csr_req_ready,
  input  logic [UUID_BITS-1:0]     csr_req_uuid,
  input  logic [NW_BITS-1:0]       csr_req_wid,
  input  logic [1:0]               csr_req_op,
  input  logic [11:0]              csr_req_addr,
  input  logic [31:0]              csr_req_wdata,
  output logic                     csr_rsp_valid,
  input  logic                     csr_rsp_ready,
  output logic [UUID_BITS-1:0]     csr_rsp_uuid,
  output logic [NW_BITS-1:0]       csr_rsp_wid,
  output logic [31:0]              csr_rsp_rdata,
  output logic [NUM_WARPS-1:0]     csr_pending,
  output logic [15:0]              perf_fflags_cnt
);

  state_e               state_q;
  logic                 rsp_valid_q;
  logic [UUID_BITS-1:0] rsp_uuid_q;
  wid_t                 rsp_wid_q;
  logic [7:0]           rsp_rdata_q;
  logic [NUM_WARPS-1:0] pending_q, pending_d;

  logic       same_wid_write;
  logic       accept;
  logic       rsp_fire;
  logic       csr_we;
  logic [7:0] csr_old;
  logic [7:0] csr_new;
  csr_op_e    req_op;

  // Upper operand bits never reach any fcsr field.
  logic unused_wdata;
  assign unused_wdata = ^csr_req_wdata[31:8];

  assign req_op         = csr_op_e'(csr_req_op);
  assign same_wid_write = fpu_write_enable & (fpu_write_wid == csr_req_wid);
  assign csr_req_ready  = ((state_q == StIdle) | csr_rsp_ready)
                          & ~fpu_pending[csr_req_wid] & ~same_wid_write;
  assign accept         = csr_req_valid & csr_req_ready;
  assign rsp_fire       = rsp_valid_q & csr_rsp_ready;
  assign csr_new        = csr_alu(req_op, csr_old, csr_req_wdata[7:0]);
  assign csr_we         = accept & (req_op != CsrOpRead);

  assign csr_rsp_valid = rsp_valid_q;
  assign csr_rsp_uuid  = rsp_uuid_q;
  assign csr_rsp_wid   = rsp_wid_q;
  assign csr_rsp_rdata = {24'b0, rsp_rdata_q};
  assign csr_pending   = pending_q;

  rv_fcsr_bank u_bank (
    .clk         (clk),
    .reset       (reset),
    .rd_wid      (fpu_read_wid),
    .rd_frm      (fpu_read_frm),
    .csr_wid     (csr_req_wid),
    .csr_addr    (csr_req_addr),
    .csr_old     (csr_old),
    .csr_we      (csr_we),
    .csr_new     (csr_new),
    .flag_we     (fpu_write_enable),
    .flag_wid    (fpu_write_wid),
    .flag_fflags (fpu_write_fflags)
  );

  // Request/response FSM with registered response payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rsp_valid_q <= 1'b0;
      rsp_uuid_q  <= '0;
      rsp_wid_q   <= '0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rsp_uuid_q  <= csr_req_uuid;
            rsp_wid_q   <= csr_req_wid;
            rsp_rdata_q <= csr_old;
          end
        end
        StResp: begin
          if (csr_rsp_ready) begin
            if (accept) begin
              rsp_uuid_q  <= csr_req_uuid;
              rsp_wid_q   <= csr_req_wid;
              rsp_rdata_q <= csr_old;
            end else begin
              state_q     <= StIdle;
              rsp_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Pending bits: retire on response handshake, set on accept (set wins for the same warp).
  always_comb begin
    pending_d = pending_q;
    if (rsp_fire) pending_d[rsp_wid_q] = 1'b0;
    if (accept)   pending_d[csr_req_wid] = 1'b1;
  end

  // Pending vector register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending_q <= '0;
    else        pending_q <= pending_d;
  end

`ifdef FPU_FFLAGS_CNT_EN
  logic [15:0] cnt_q;

  // Saturating count of FPU flag writes that raise at least one flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (fpu_write_enable && (|fpu_write_fflags) && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign perf_fflags_cnt = cnt_q;
`else
  assign perf_fflags_cnt = '0;
`endif

endmodule

// File: tb/tb_rv_fpu_csr_responder.sv
// Directed self-checking bench for rv_fpu_csr_responder.
module tb_rv_fpu_csr_responder;
  import rv_fpu_csr_responder_pkg::*;

  logic                     clk;
  logic                     reset;
  logic [NW_BITS-1:0]       fpu_read_wid;
  logic [INST_FRM_BITS-1:0] fpu_read_frm;
  logic                     fpu_write_enable;
  logic [NW_BITS-1:0]       fpu_write_wid;
  logic [FFLAGS_BITS-1:0]   fpu_write_fflags;
  logic [NUM_WARPS-1:0]     fpu_pending;
  logic                     csr_req_valid;
  logic                     csr_req_ready;
  logic [UUID_BITS-1:0]     csr_req_uuid;
  logic [NW_BITS-1:0]       csr_req_wid;
  logic [1:0]               csr_req_op;
  logic [11:0]              csr_req_addr;
  logic [31:0]              csr_req_wdata;
  logic                     csr_rsp_valid;
  logic                     csr_rsp_ready;
  logic [UUID_BITS-1:0]     csr_rsp_uuid;
  logic [NW_BITS-1:0]       csr_rsp_wid;
  logic [31:0]              csr_rsp_rdata;
  logic [NUM_WARPS-1:0]     csr_pending;
  logic [15:0]              perf_fflags_cnt;

  int n_checks = 0;
  int n_errors = 0;

  rv_fpu_csr_responder #(.CORE_ID(0)) dut (
    .clk              (clk),
    .reset            (reset),
    .fpu_read_wid     (fpu_read_wid),
    .fpu_read_frm     (fpu_read_frm),
    .fpu_write_enable (fpu_write_enable),
    .fpu_write_wid    (fpu_write_wid),
    .fpu_write_fflags (fpu_write_fflags),
    .fpu_pending      (fpu_pending),
    .csr_req_valid    (csr_req_valid),
    .csr_req_ready    (csr_req_ready),
    .csr_req_uuid     (csr_req_uuid),
    .csr_req_wid      (csr_req_wid),
    .csr_req_op       (csr_req_op),
    .csr_req_addr     (csr_req_addr),
    .csr_req_wdata    (csr_req_wdata),
    .csr_rsp_valid    (csr_rsp_valid),
    .csr_rsp_ready    (csr_rsp_ready),
    .csr_rsp_uuid     (csr_rsp_uuid),
    .csr_rsp_wid      (csr_rsp_wid),
    .csr_rsp_rdata    (csr_rsp_rdata),
    .csr_pending      (csr_pending),
    .perf_fflags_cnt  (perf_fflags_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // One full request/response with rsp_ready held high; returns the response data.
  task automatic csr_do(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                        input logic [NW_BITS-1:0] wid, input logic [7:0] uuid,
                        output logic [31:0] rdata);
    int n;
    @(negedge clk);
    csr_req_valid = 1'b1;
    csr_req_op    = op;
    csr_req_addr  = addr;
    csr_req_wdata = wdata;
    csr_req_wid   = wid;
    csr_req_uuid  = uuid;
    csr_rsp_ready = 1'b1;
    n = 0;
    #1;
    while (!csr_req_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) check_eq("req_ready_timeout", 32'(csr_req_ready), 32'd1);
    @(negedge clk);
    csr_req_valid = 1'b0;
    check_eq("rsp_valid_after_accept", 32'(csr_rsp_valid), 32'd1);
    check_eq("rsp_uuid", 32'(csr_rsp_uuid), 32'(uuid));
    check_eq("csr_pending_set", 32'(csr_pending[wid]), 32'd1);
    rdata = csr_rsp_rdata;
    @(negedge clk);
    check_eq("rsp_valid_after_hs", 32'(csr_rsp_valid), 32'd0);
    check_eq("csr_pending_clr", 32'(csr_pending[wid]), 32'd0);
  endtask

  logic [31:0] rd;

  initial begin
    reset = 1'b0;
    fpu_read_wid = '0;
    fpu_write_enable = 1'b0;
    fpu_write_wid = '0;
    fpu_write_fflags = '0;
    fpu_pending = '0;
    csr_req_valid = 1'b0;
    csr_req_uuid = '0;
    csr_req_wid = '0;
    csr_req_op = '0;
    csr_req_addr = '0;
    csr_req_wdata = '0;
    csr_rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("reset_rsp_valid", 32'(csr_rsp_valid), 32'd0);
    check_eq("reset_csr_pending", 32'(csr_pending), 32'd0);
    check_eq("reset_perf", 32'(perf_fflags_cnt), 32'd0);
    check_eq("reset_frm", 32'(fpu_read_frm), 32'd0);
    reset = 1'b1;

    // 1: RS frm with zero mask on warp 0
    csr_do(2'b10, 12'h002, 32'h0, 2'd0, 8'h10, rd);
    check_eq("t1_rdata", rd, 32'h0);
    check_eq("t1_read_frm", 32'(fpu_read_frm), 32'd0);

    // 2: RW fcsr = E5 on warp 1
    csr_do(2'b01, 12'h003, 32'hFFFF_FFE5, 2'd1, 8'h20, rd);
    check_eq("t2_old", rd, 32'h0);
    fpu_read_wid = 2'd1;
    #1;
    check_eq("t2_read_frm", 32'(fpu_read_frm), 32'd7);
    csr_do(2'b10, 12'h001, 32'h0, 2'd1, 8'h21, rd);
    check_eq("t2_fflags", rd, 32'h5);
    csr_do(2'b00, 12'h002, 32'h0, 2'd1, 8'h22, rd);
    check_eq("t2_frm", rd, 32'h7);
    csr_do(2'b10, 12'h003, 32'h0, 2'd1, 8'h23, rd);
    check_eq("t2_fcsr", rd, 32'hE5);

    // Unknown address: reads zero and leaves state untouched
    csr_do(2'b01, 12'h004, 32'hFF, 2'd1, 8'h24, rd);
    check_eq("unk_rdata", rd, 32'h0);
    csr_do(2'b10, 12'h003, 32'h0, 2'd1, 8'h25, rd);
    check_eq("unk_no_change", rd, 32'hE5);

    // 3: sticky FPU flags on warp 2, then RC clears them
    @(negedge clk);
    fpu_write_enable = 1'b1;
    fpu_write_wid = 2'd2;
    fpu_write_fflags = 5'b00001;
    @(negedge clk);
    fpu_write_fflags = 5'b10000;
    @(negedge clk);
    fpu_write_enable = 1'b0;
    fpu_write_fflags = '0;
    csr_do(2'b11, 12'h001, 32'h1F, 2'd2, 8'h30, rd);
    check_eq("t3_rc_old", rd, 32'h11);
    csr_do(2'b10, 12'h001, 32'h0, 2'd2, 8'h31, rd);
    check_eq("t3_cleared", rd, 32'h0);

    // 4: FPU pending on warp 3 blocks the request
    @(negedge clk);
    fpu_pending = 4'b1000;
    csr_rsp_ready = 1'b0;
    csr_req_valid = 1'b1;
    csr_req_wid = 2'd3;
    csr_req_op = 2'b10;
    csr_req_addr = 12'h003;
    csr_req_wdata = 32'h0;
    csr_req_uuid = 8'h40;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t4_ready_blocked", 32'(csr_req_ready), 32'd0);
      @(negedge clk);
    end
    check_eq("t4_no_pending", 32'(csr_pending[3]), 32'd0);
    fpu_pending = '0;
    #1;
    check_eq("t4_ready_free", 32'(csr_req_ready), 32'd1);
    @(negedge clk);
    csr_req_valid = 1'b0;
    check_eq("t4_pending_set", 32'(csr_pending[3]), 32'd1);
    check_eq("t4_rsp_valid", 32'(csr_rsp_valid), 32'd1);
    @(negedge clk);
    check_eq("t4_pending_held", 32'(csr_pending[3]), 32'd1);
    csr_rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("t4_pending_clr", 32'(csr_pending[3]), 32'd0);
    check_eq("t4_rsp_done", 32'(csr_rsp_valid), 32'd0);

    // 5: response backpressure with a second request queued
    csr_rsp_ready = 1'b0;
    csr_req_valid = 1'b1;
    csr_req_wid = 2'd1;
    csr_req_op = 2'b10;
    csr_req_addr = 12'h002;
    csr_req_uuid = 8'h51;
    @(negedge clk);
    csr_req_addr = 12'h001;
    csr_req_uuid = 8'h52;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t5_rsp_valid", 32'(csr_rsp_valid), 32'd1);
      check_eq("t5_rsp_uuid", 32'(csr_rsp_uuid), 32'h51);
      check_eq("t5_rsp_rdata", csr_rsp_rdata, 32'h7);
      check_eq("t5_req_stalled", 32'(csr_req_ready), 32'd0);
      @(negedge clk);
    end
    csr_rsp_ready = 1'b1;
    #1;
    check_eq("t5_req_ready", 32'(csr_req_ready), 32'd1);
    @(negedge clk);
    csr_req_valid = 1'b0;
    check_eq("t5_rsp2_valid", 32'(csr_rsp_valid), 32'd1);
    check_eq("t5_rsp2_uuid", 32'(csr_rsp_uuid), 32'h52);
    check_eq("t5_rsp2_rdata", csr_rsp_rdata, 32'h5);
    check_eq("t5_pending_setwins", 32'(csr_pending[1]), 32'd1);
    @(negedge clk);
    check_eq("t5_idle", 32'(csr_rsp_valid), 32'd0);
    check_eq("t5_pending_clr", 32'(csr_pending[1]), 32'd0);

    // Same-warp FPU write gates the CSR request
    csr_req_valid = 1'b1;
    csr_req_wid = 2'd0;
    fpu_write_enable = 1'b1;
    fpu_write_wid = 2'd0;
    fpu_write_fflags = 5'b00000;
    #1;
    check_eq("same_wid_block", 32'(csr_req_ready), 32'd0);
    csr_req_valid = 1'b0;
    fpu_write_enable = 1'b0;

    // 6: performance counter
`ifdef FPU_FFLAGS_CNT_EN
    @(negedge clk);
    fpu_write_enable = 1'b1;
    fpu_write_fflags = 5'b00000;
    @(negedge clk);
    check_eq("t6_zero_no_count", 32'(perf_fflags_cnt), 32'd2);
    fpu_write_fflags = 5'b00100;
    repeat (70000) @(negedge clk);
    fpu_write_enable = 1'b0;
    check_eq("t6_saturated", 32'(perf_fflags_cnt), 32'hFFFF);
`else
    @(negedge clk);
    fpu_write_enable = 1'b1;
    fpu_write_fflags = 5'b00100;
    repeat (10) @(negedge clk);
    fpu_write_enable = 1'b0;
    check_eq("t6_cnt_disabled", 32'(perf_fflags_cnt), 32'd0);
`endif

    // Asynchronous reset mid-response drops it
    @(negedge clk);
    csr_rsp_ready = 1'b0;
    csr_req_valid = 1'b1;
    csr_req_wid = 2'd1;
    @(negedge clk);
    csr_req_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_rsp_valid", 32'(csr_rsp_valid), 32'd0);
    check_eq("arst_pending", 32'(csr_pending), 32'd0);
    fpu_read_wid = 2'd1;
    #1;
    check_eq("arst_frm", 32'(fpu_read_frm), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
